// File: rtl/rtc_bus_sequencer.sv
// Sequences one host read/write through the external RTC control-signal generator and drives the multiplexed AD bus.
// Optional WAIT_DONE timeout is compiled in when the macro RTC_SEQ_TIMEOUT_EN is defined.

module rtc_bus_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       gen_en_funcion,
  output logic       gen_escribir_leer,
  input  logic       gen_direccion_dato,
  input  logic       gen_flag_done,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, DRAIN, RESP} state_e;

  state_e     state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       error_d;
  logic       timeout_hit;
  logic       active_d;

  logic       ready_q;
  logic       valid_q;
  logic       error_q;
  logic       gen_en_q;
  logic       gen_wr_q;
  logic [7:0] ad_out_q;
  logic       ad_oe_q;

`ifdef RTC_SEQ_TIMEOUT_EN
  logic [5:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == START) begin
      tmo_d = 6'd0;
    end else if (state_q == WAIT_DONE) begin
      tmo_d = tmo_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= 6'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  // Counter value 62 marks the 63rd WAIT_DONE cycle without a done flag.
  assign timeout_hit = (state_q == WAIT_DONE) && (tmo_q == 6'd62);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done flag on the last timeout cycle still counts as success.
        if (gen_flag_done) begin
          if (!write_q) begin
            rdata_d = ad_in;
          end
          drain_d = 2'd0;
          state_d = DRAIN;
        end else if (timeout_hit) begin
          if (!write_q) begin
            rdata_d = 8'h00;
          end
          error_d = 1'b1;
          state_d = RESP;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd3) begin
          state_d = RESP;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign active_d = (state_d == START) || (state_d == WAIT_DONE) || (state_d == DRAIN);

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      drain_q  <= 2'd0;
      write_q  <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      gen_en_q <= 1'b0;
      gen_wr_q <= 1'b0;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= (state_d == IDLE);
      valid_q  <= (state_d == RESP);
      error_q  <= error_d;
      gen_en_q <= (state_d == START);
      gen_wr_q <= active_d & write_d;
      ad_out_q <= active_d ? (gen_direccion_dato ? wdata_d : addr_d) : 8'h00;
      ad_oe_q  <= active_d & (write_d | ~gen_direccion_dato);
    end
  end

  assign req_ready         = ready_q;
  assign rsp_valid         = valid_q;
  assign rsp_rdata         = rdata_q;
  assign rsp_error         = error_q;
  assign gen_en_funcion    = gen_en_q;
  assign gen_escribir_leer = gen_wr_q;
  assign ad_out            = ad_out_q;
  assign ad_oe             = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: a timeline model predicts every output each cycle,
// and a behavioural RTC generator answers the start pulses.

module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reqValid = 1'b0;
  logic       reqWrite = 1'b0;
  logic [7:0] reqAddr = 8'h00;
  logic [7:0] reqWdata = 8'h00;
  logic       genDirDato = 1'b0;
  logic       genFlagDone = 1'b0;
  logic [7:0] adIn = 8'h00;

  logic       reqReady;
  logic       rspValid;
  logic [7:0] rspRdata;
  logic       rspError;
  logic       genEn;
  logic       genWr;
  logic [7:0] adOut;
  logic       adOe;

  rtc_bus_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (reqValid),
    .req_ready          (reqReady),
    .req_write          (reqWrite),
    .req_addr           (reqAddr),
    .req_wdata          (reqWdata),
    .rsp_valid          (rspValid),
    .rsp_rdata          (rspRdata),
    .rsp_error          (rspError),
    .gen_en_funcion     (genEn),
    .gen_escribir_leer  (genWr),
    .gen_direccion_dato (genDirDato),
    .gen_flag_done      (genFlagDone),
    .ad_out             (adOut),
    .ad_oe              (adOe),
    .ad_in              (adIn)
  );

  always #5 clk = ~clk;

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  int compCount = 0;
  int failCount = 0;
  int edgeNum = 0;

  // Timeline model: a transaction is described by its acceptance edge and its response edge.
  bit         mTxn = 1'b0;
  bit         mWrite = 1'b0;
  bit         mTimeout = 1'b0;
  bit         mSeenEdge = 1'b0;
  bit         mReadyPrev = 1'b0;
  int         mAccEdge = 0;
  int         mRspEdge = -1;
  logic [7:0] mAddr = 8'h00;
  logic [7:0] mWdata = 8'h00;
  logic [7:0] mRdata = 8'h00;

  logic       expReady = 1'b0;
  logic       expValid = 1'b0;
  logic       expError = 1'b0;
  logic       expGenEn = 1'b0;
  logic       expGenWr = 1'b0;
  logic       expAdOe = 1'b0;
  logic [7:0] expAdOut = 8'h00;
  logic [7:0] expRdata = 8'h00;

  int         genStart = -1;
  bit         flagEnable = 1'b1;
  bit         spuriousPending = 1'b0;
  logic [7:0] genReadData = 8'h00;

  logic       obsGenEn1 = 1'b0;
  logic       obsDir1 = 1'b0;
  logic       obsAdOe6 = 1'b0;
  logic       obsAdOe15 = 1'b0;
  logic [7:0] obsAdOut6 = 8'h00;
  logic [7:0] obsAdOut15 = 8'h00;

  function automatic logic [7:0] b8(input logic b);
    return {7'b0, b};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    mTxn = 1'b0;
    mTimeout = 1'b0;
    mSeenEdge = 1'b0;
    mReadyPrev = 1'b0;
    mRspEdge = -1;
    mWrite = 1'b0;
    mAddr = 8'h00;
    mWdata = 8'h00;
    mRdata = 8'h00;
    expReady = 1'b0;
    expValid = 1'b0;
    expError = 1'b0;
    expGenEn = 1'b0;
    expGenWr = 1'b0;
    expAdOe = 1'b0;
    expAdOut = 8'h00;
    expRdata = 8'h00;
  endfunction

  // Start at A, done flag honoured from A+2, response 4 edges after done (or at A+64 on timeout).
  function automatic void modelEdge();
    int  m;
    bit  act;
    m = edgeNum;
    if (mTxn && mRspEdge >= 0 && m == mRspEdge + 1) mTxn = 1'b0;
    if (!mTxn && mReadyPrev && reqValid) begin
      mTxn = 1'b1;
      mAccEdge = m;
      mRspEdge = -1;
      mTimeout = 1'b0;
      mWrite = reqWrite;
      mAddr = reqAddr;
      mWdata = reqWdata;
    end else if (mTxn && mRspEdge < 0) begin
      if (genFlagDone && m >= mAccEdge + 2) begin
        mRspEdge = m + 4;
        if (!mWrite) mRdata = adIn;
      end else if (TimeoutEn && m == mAccEdge + 64) begin
        mRspEdge = m;
        mTimeout = 1'b1;
        if (!mWrite) mRdata = 8'h00;
      end
    end
    mSeenEdge = 1'b1;
    act = mTxn && (mRspEdge < 0 || m < mRspEdge);
    expGenEn = mTxn && (m == mAccEdge);
    expValid = mTxn && (m == mRspEdge);
    expReady = mSeenEdge && !mTxn;
    expError = expValid && mTimeout;
    expGenWr = act && mWrite;
    expAdOut = act ? (genDirDato ? mWdata : mAddr) : 8'h00;
    expAdOe = act && (mWrite || !genDirDato);
    expRdata = mRdata;
    mReadyPrev = expReady;
  endfunction

  // Compare process: outputs are settled by the falling edge.
  always @(negedge clk) begin
    edgeNum++;
    if (!reset) modelReset();
    else modelEdge();
    checkOutput("req_ready", b8(reqReady), b8(expReady));
    checkOutput("rsp_valid", b8(rspValid), b8(expValid));
    checkOutput("rsp_error", b8(rspError), b8(expError));
    checkOutput("rsp_rdata", rspRdata, expRdata);
    checkOutput("gen_en_funcion", b8(genEn), b8(expGenEn));
    checkOutput("gen_escribir_leer", b8(genWr), b8(expGenWr));
    checkOutput("ad_out", adOut, expAdOut);
    checkOutput("ad_oe", b8(adOe), b8(expAdOe));
  end

  // One clock, then the generator model prepares its inputs for the next rising edge.
  task automatic tick();
    int  s;
    int  age;
    bit  busy;
    @(posedge clk);
    @(negedge clk);
    #1;
    if (!reset) begin
      genStart = -1;
      genFlagDone = 1'b0;
      genDirDato = 1'b0;
      adIn = 8'h00;
      spuriousPending = 1'b0;
    end else begin
      s = edgeNum + 1;
      if (genEn) begin
        busy = (genStart >= 0) && ((s - genStart) <= 21);
        checkOutput("gen_start_while_busy", b8(busy), 8'h00);
        genStart = s;
      end
      age = (genStart >= 0) ? (s - genStart) : -1;
      genDirDato = (age >= 11) && (age <= 21);
      genFlagDone = (flagEnable && age == 21) || spuriousPending;
      spuriousPending = 1'b0;
      adIn = genDirDato ? genReadData : 8'hC3;
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic [7:0] rd, input bit hold, input int spurAt,
                               input int limit, output int lat);
    int n;
    n = 0;
    while (!reqReady && n < 60) begin
      tick();
      n++;
    end
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr = addr;
    reqWdata = wdata;
    genReadData = rd;
    lat = 0;
    do begin
      if (lat + 1 == spurAt) spuriousPending = 1'b1;
      tick();
      lat++;
      if (lat == 1 && !hold) reqValid = 1'b0;
      if (hold && lat == 5) reqAddr = addr + 8'h01;
      if (lat == 1) begin
        obsGenEn1 = genEn;
        obsDir1 = genWr;
      end
      if (lat == 6) begin
        obsAdOut6 = adOut;
        obsAdOe6 = adOe;
      end
      if (lat == 15) begin
        obsAdOut15 = adOut;
        obsAdOe15 = adOe;
      end
    end while (!rspValid && lat < limit);
  endtask

  initial begin
    int lat;
    int n;
    int seen;

    repeat (3) tick();
    checkOutput("ready_in_reset", b8(reqReady), 8'h00);
    reset = 1'b1;
    tick();
    checkOutput("ready_after_release", b8(reqReady), 8'h01);

    $display("[TB] read addr 0x04");
    applyStimulus(1'b0, 8'h04, 8'h00, 8'h37, 1'b0, 24, 100, lat);
    checkOutput("read_latency", lat[7:0], 8'd27);
    checkOutput("read_rdata", rspRdata, 8'h37);
    checkOutput("read_error", b8(rspError), 8'h00);
    checkOutput("read_gen_en_cycle1", b8(obsGenEn1), 8'h01);
    checkOutput("read_oe_addr_phase", b8(obsAdOe6), 8'h01);
    checkOutput("read_oe_data_phase", b8(obsAdOe15), 8'h00);

    $display("[TB] write addr 0x02 data 0x59");
    applyStimulus(1'b1, 8'h02, 8'h59, 8'h00, 1'b0, 0, 100, lat);
    checkOutput("write_latency", lat[7:0], 8'd27);
    checkOutput("write_rdata_kept", rspRdata, 8'h37);
    checkOutput("write_dir", b8(obsDir1), 8'h01);
    checkOutput("write_ad_addr", obsAdOut6, 8'h02);
    checkOutput("write_ad_data", obsAdOut15, 8'h59);
    checkOutput("write_oe_data_phase", b8(obsAdOe15), 8'h01);

    $display("[TB] stray done flag while idle");
    spuriousPending = 1'b1;
    tick();
    tick();
    checkOutput("idle_ignores_done", b8(rspValid), 8'h00);
    checkOutput("idle_still_ready", b8(reqReady), 8'h01);

    $display("[TB] back-to-back requests");
    applyStimulus(1'b0, 8'h10, 8'h00, 8'h8E, 1'b1, 0, 100, lat);
    checkOutput("b2b_first_latency", lat[7:0], 8'd27);
    checkOutput("b2b_first_addr", obsAdOut6, 8'h10);
    n = 0;
    while (!genEn && n < 10) begin
      tick();
      n++;
    end
    reqValid = 1'b0;
    checkOutput("b2b_restart_gap", n[7:0], 8'd2);
    lat = 1;
    while (!rspValid && lat < 100) begin
      tick();
      lat++;
    end
    checkOutput("b2b_second_latency", lat[7:0], 8'd27);
    checkOutput("b2b_second_rdata", rspRdata, 8'h8E);

    $display("[TB] reset during a read");
    n = 0;
    while (!reqReady && n < 60) begin
      tick();
      n++;
    end
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqAddr = 8'h04;
    genReadData = 8'h21;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) reqValid = 1'b0;
    end
    reset = 1'b0;
    #1;
    checkOutput("rst_req_ready", b8(reqReady), 8'h00);
    checkOutput("rst_rsp_valid", b8(rspValid), 8'h00);
    checkOutput("rst_gen_en", b8(genEn), 8'h00);
    checkOutput("rst_gen_dir", b8(genWr), 8'h00);
    checkOutput("rst_ad_oe", b8(adOe), 8'h00);
    checkOutput("rst_ad_out", adOut, 8'h00);
    checkOutput("rst_rdata", rspRdata, 8'h00);
    tick();
    tick();
    reset = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (rspValid) seen++;
    end
    checkOutput("rst_no_response", seen[7:0], 8'd0);
    applyStimulus(1'b0, 8'h06, 8'h00, 8'h4B, 1'b0, 0, 100, lat);
    checkOutput("post_rst_latency", lat[7:0], 8'd27);
    checkOutput("post_rst_rdata", rspRdata, 8'h4B);

    $display("[TB] done flag tied low");
    flagEnable = 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
    applyStimulus(1'b0, 8'h05, 8'h00, 8'h99, 1'b0, 0, 100, lat);
    checkOutput("timeout_latency", lat[7:0], 8'd65);
    checkOutput("timeout_error", b8(rspError), 8'h01);
    checkOutput("timeout_rdata", rspRdata, 8'h00);
`else
    applyStimulus(1'b0, 8'h05, 8'h00, 8'h99, 1'b0, 0, 80, lat);
    checkOutput("hang_no_response", b8(rspValid), 8'h00);
    checkOutput("hang_loop_length", lat[7:0], 8'd80);
    checkOutput("hang_not_ready", b8(reqReady), 8'h00);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("hang_recovered", b8(reqReady), 8'h01);
`endif
    flagEnable = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d, mismatched %0d", compCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 clk  in  1  system clock; every register samples on the rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 req_valid  in  1  host transaction request.
REQ-004 req_ready  out  1  sequencer idle, request accepted this cycle.
REQ-005 req_write  in  1  1 = RTC register write, 0 = read.
REQ-006 req_addr  in  8  RTC register address.
REQ-007 req_wdata  in  8  write data.
REQ-008 rsp_valid  out  1  one-cycle completion pulse.
REQ-009 rsp_rdata  out  8  read data.
REQ-010 rsp_error  out  1  timeout flag, qualified by rsp_valid.
REQ-011 gen_en_funcion  out  1  start pulse to the RTC control-signal generator.
REQ-012 gen_escribir_leer  out  1  direction to the generator (1 = write).
REQ-013 gen_direccion_dato  in  1  from the generator: 0 = address phase, 1 = data phase.
REQ-014 gen_flag_done  in  1  from the generator; high for exactly one cycle at its count 20.
REQ-015 ad_out  out  8  value driven onto the multiplexed AD bus.
REQ-016 ad_oe  out  1  AD bus output enable (tristate at top level).
REQ-017 ad_in  in  8  AD bus sampled value.

Function
REQ-018 FSM states: IDLE, START, WAIT_DONE, DRAIN, RESP; every output is registered.
REQ-019 IDLE: req_ready=1; on req_valid, latch req_write/req_addr/req_wdata, go to START; later input changes are ignored until the next IDLE.
REQ-020 START: gen_en_funcion=1 for exactly one cycle, then WAIT_DONE; gen_en_funcion=0 in every other state.
REQ-021 gen_escribir_leer = latched req_write from START through DRAIN; 0 in IDLE.
REQ-022 ad_out = latched addr when gen_direccion_dato=0, latched wdata when 1, during START..DRAIN; 0x00 in IDLE.
REQ-023 ad_oe = 1 in START..DRAIN when write, or when read and gen_direccion_dato=0; otherwise 0, so the bus is released during the read data phase.
REQ-024 WAIT_DONE: on gen_flag_done=1, capture ad_in into rsp_rdata if read; writes leave rsp_rdata unchanged; go to DRAIN.
REQ-025 DRAIN: exactly 4 cycles, so the generator is back in its wait state before any new start pulse; then RESP.
REQ-026 RESP: rsp_valid=1 for one cycle, req_ready=0, then IDLE; no backpressure.
REQ-027 Nominal latency: acceptance at cycle 0, gen_en_funcion at cycle 1, gen_flag_done at cycle 22, rsp_valid at cycle 27.
REQ-028 gen_flag_done outside WAIT_DONE is ignored.
REQ-029 req_valid outside IDLE is ignored and the request is not queued.

Reset
REQ-030 reset=0 forces IDLE immediately, from any state.
REQ-031 While reset=0: req_ready=0, then 1 in the first cycle after release.
REQ-032 While reset=0: rsp_valid, rsp_error, gen_en_funcion, gen_escribir_leer and ad_oe are 0.
REQ-033 While reset=0: rsp_rdata=0x00, ad_out=0x00 and all latches are cleared.
REQ-034 A transaction interrupted by reset produces no rsp_valid.

Configuration
REQ-035 With macro RTC_SEQ_TIMEOUT_EN defined, a 6-bit counter runs in WAIT_DONE.
REQ-036 After 63 WAIT_DONE cycles without gen_flag_done, go to RESP with rsp_error=1; for a read, rsp_rdata=0x00.
REQ-037 The timeout path skips DRAIN.
REQ-038 Without RTC_SEQ_TIMEOUT_EN, WAIT_DONE waits indefinitely and rsp_error is constant 0.

Verification
REQ-039 Read addr 0x04, model drives ad_in=0x37 in data phase -> ad_oe high only in address phase, rsp_rdata=0x37, rsp_valid at cycle 27, rsp_error=0.
REQ-040 Write addr 0x02 data 0x59 -> ad_out 0x02 then 0x59, ad_oe held high, gen_escribir_leer=1, rsp_rdata unchanged.
REQ-041 Back-to-back requests with req_valid held high -> second gen_en_funcion 2 cycles after the first rsp_valid, never while the generator is active.
REQ-042 reset=0 at cycle 10 of a read -> all outputs at reset values at once, no rsp_valid, next request completes normally.
REQ-043 RTC_SEQ_TIMEOUT_EN defined, gen_flag_done tied 0 -> rsp_valid with rsp_error=1 and rsp_rdata=0x00 after 63 WAIT_DONE cycles.
REQ-044 Macro undefined, gen_flag_done tied 0 -> no rsp_valid, req_ready stays 0.
